// File: rtl/alu_mc_controller.sv
// Multicycle control FSM for the 16-bit simplified MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the ALU op each cycle.
module alu_mc_controller #(
    parameter int PC_INC = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic [2:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [3:0]       ALUControl,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSource,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_J    = 4'b0010;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    // ALUSrcB code that presents the PC_INC constant to the ALU during fetch.
    localparam logic [1:0] SRCB_INC = (PC_INC > 0) ? 2'b01 : 2'b00;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic [2:0]       r_funct;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic [3:0] w_rAlu;
    logic [3:0] w_aluCtl;
    logic       w_srcA;
    logic [1:0] w_srcB;
    logic       w_iorD;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_pcWrite;
    logic [1:0] w_pcSource;
    logic       w_regDst;
    logic       w_regWrite;
    logic       w_memtoReg;
    logic       w_retire;

    always_comb begin
        w_rAlu = ALU_AND;
        case (r_funct)
            3'b000:  w_rAlu = ALU_AND;
            3'b001:  w_rAlu = ALU_OR;
            3'b010:  w_rAlu = ALU_ADD;
            3'b011:  w_rAlu = ALU_SUB;
            3'b100:  w_rAlu = ALU_SLT;
            3'b101:  w_rAlu = ALU_NOR;
            3'b110:  w_rAlu = ALU_NAND;
            default: w_rAlu = ALU_AND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_aluCtl   = ALU_AND;
        w_srcA     = 1'b0;
        w_srcB     = 2'b00;
        w_iorD     = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_irWrite  = 1'b0;
        w_pcWrite  = 1'b0;
        w_pcSource = 2'b00;
        w_regDst   = 1'b0;
        w_regWrite = 1'b0;
        w_memtoReg = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memRead = 1'b1;
                w_srcB    = SRCB_INC;
                w_aluCtl  = ALU_ADD;
                if (mem_ready) begin
                    w_irWrite = 1'b1;
                    w_pcWrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_srcB   = 2'b11;
                w_aluCtl = ALU_ADD;
                case (opcode)
                    OP_R:          w_next = (funct == 3'b111) ? S_TRAP : S_EXEC_R;
                    OP_ADDI:       w_next = S_EXEC_I;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    default:       w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                w_srcA   = 1'b1;
                w_aluCtl = w_rAlu;
                w_next   = S_R_WB;
            end
            S_R_WB: begin
                w_regDst   = 1'b1;
                w_regWrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXEC_I: begin
                w_srcA   = 1'b1;
                w_srcB   = 2'b10;
                w_aluCtl = ALU_ADD;
                w_next   = S_I_WB;
            end
            S_I_WB: begin
                w_regWrite = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_srcA   = 1'b1;
                w_srcB   = 2'b10;
                w_aluCtl = ALU_ADD;
                w_next   = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_iorD    = 1'b1;
                w_memRead = 1'b1;
                if (mem_ready) begin
                    w_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_regWrite = 1'b1;
                w_memtoReg = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                w_iorD     = 1'b1;
                w_memWrite = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_srcA     = 1'b1;
                w_aluCtl   = ALU_SUB;
                w_pcSource = 2'b01;
                w_pcWrite  = (r_op == OP_BEQ) ? zero : ~zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                w_pcSource = 2'b10;
                w_pcWrite  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Later states work from the instruction fields captured in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 4'b0000;
            r_funct   <= 3'b000;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_op    <= opcode;
                r_funct <= funct;
            end
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign ALUControl = rst_n ? w_aluCtl   : 4'b0000;
    assign ALUSrcA    = rst_n ? w_srcA     : 1'b0;
    assign ALUSrcB    = rst_n ? w_srcB     : 2'b00;
    assign IorD       = rst_n ? w_iorD     : 1'b0;
    assign MemRead    = rst_n ? w_memRead  : 1'b0;
    assign MemWrite   = rst_n ? w_memWrite : 1'b0;
    assign IRWrite    = rst_n ? w_irWrite  : 1'b0;
    assign PCWrite    = rst_n ? w_pcWrite  : 1'b0;
    assign PCSource   = rst_n ? w_pcSource : 2'b00;
    assign RegDst     = rst_n ? w_regDst   : 1'b0;
    assign RegWrite   = rst_n ? w_regWrite : 1'b0;
    assign MemtoReg   = rst_n ? w_memtoReg : 1'b0;
    assign illegal    = r_illegal;
    assign state      = r_state;
    assign retired    = r_retired;

endmodule

// File: tb/tb_alu_mc_controller.sv
// Testbench for alu_mc_controller: per-cycle expectation vectors fed through a scoreboard queue,
// plus hand-built sequences for memory stalls, counter wrap and reset during a store.
module tb_alu_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [2:0]  funct = 3'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic [3:0]  ALUControl;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSource;
    logic        RegDst;
    logic        RegWrite;
    logic        MemtoReg;
    logic        illegal;
    logic [3:0]  state;
    logic [15:0] retired;

    alu_mc_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .illegal(illegal), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Control word layout: ALUControl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
    // IRWrite, PCWrite, PCSource, RegDst, RegWrite, MemtoReg, illegal.
    logic [17:0] actCtrl;
    assign actCtrl = {ALUControl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                      PCWrite, PCSource, RegDst, RegWrite, MemtoReg, illegal};

    localparam logic [17:0] C_ZERO        = 18'b0000_0_00_0_0_0_0_0_00_0_0_0_0;
    localparam logic [17:0] C_FETCH_STALL = 18'b0010_0_01_0_1_0_0_0_00_0_0_0_0;
    localparam logic [17:0] C_FETCH_GO    = 18'b0010_0_01_0_1_0_1_1_00_0_0_0_0;
    localparam logic [17:0] C_DECODE      = 18'b0010_0_11_0_0_0_0_0_00_0_0_0_0;
    localparam logic [17:0] C_R_WB        = 18'b0000_0_00_0_0_0_0_0_00_1_1_0_0;
    localparam logic [17:0] C_EXEC_I      = 18'b0010_1_10_0_0_0_0_0_00_0_0_0_0;
    localparam logic [17:0] C_I_WB        = 18'b0000_0_00_0_0_0_0_0_00_0_1_0_0;
    localparam logic [17:0] C_MEM_RD      = 18'b0000_0_00_1_1_0_0_0_00_0_0_0_0;
    localparam logic [17:0] C_MEM_WB      = 18'b0000_0_00_0_0_0_0_0_00_0_1_1_0;
    localparam logic [17:0] C_MEM_WR      = 18'b0000_0_00_1_0_1_0_0_00_0_0_0_0;
    localparam logic [17:0] C_JUMP        = 18'b0000_0_00_0_0_0_0_1_10_0_0_0_0;
    localparam logic [17:0] C_TRAP        = 18'b0000_0_00_0_0_0_0_0_00_0_0_0_1;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_J    = 4'b0010;

    function automatic logic [17:0] execR(input logic [3:0] alu);
        return {alu, 14'b1_00_0000_0_00_0000};
    endfunction

    function automatic logic [17:0] branchCtrl(input logic taken);
        return {4'b0110, 3'b100, 4'b0000, taken, 2'b01, 4'b0000};
    endfunction

    typedef struct {
        logic        rstN;
        logic [3:0]  op;
        logic [2:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic [15:0] ret;
    } vec_t;

    vec_t        vecQ[$];
    vec_t        expQ[$];
    logic [15:0] fillRet = 16'h0000;
    int          numErrors = 0;
    int          numChecks = 0;
    int          curVec = 0;
    int          irwCount = 0;

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        numChecks++;
        if (got !== want) begin
            numErrors++;
            $display("[TB] FAIL %s (vec %0d): got 0x%0h, want 0x%0h", name, curVec, got, want);
        end
    endtask

    task automatic addVec(input logic rstN, input logic [3:0] op, input logic [2:0] fn,
                          input logic z, input logic rdy, input logic [3:0] st,
                          input logic [17:0] ctrl);
        vec_t v;
        v.rstN = rstN; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.st = st; v.ctrl = ctrl; v.ret = fillRet;
        vecQ.push_back(v);
    endtask

    task automatic addReset();
        fillRet = 16'h0000;
        addVec(1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 4'd0, C_ZERO);
    endtask

    task automatic addR(input logic [2:0] fn, input logic [3:0] alu);
        addVec(1'b1, OP_R, fn, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_R, fn, 1'b0, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, OP_R, fn, 1'b0, 1'b1, 4'd2, execR(alu));
        addVec(1'b1, OP_R, fn, 1'b0, 1'b1, 4'd3, C_R_WB);
        fillRet = fillRet + 16'd1;
    endtask

    task automatic addBranch(input logic [3:0] op, input logic z, input logic taken);
        addVec(1'b1, op, 3'h0, z, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, op, 3'h0, z, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, op, 3'h0, z, 1'b1, 4'd10, branchCtrl(taken));
        fillRet = fillRet + 16'd1;
    endtask

    task automatic addJump();
        addVec(1'b1, OP_J, 3'h0, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_J, 3'h0, 1'b0, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, OP_J, 3'h0, 1'b0, 1'b1, 4'd11, C_JUMP);
        fillRet = fillRet + 16'd1;
    endtask

    task automatic addTrap(input logic [3:0] op, input logic [2:0] fn, input int cycles);
        addVec(1'b1, op, fn, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, op, fn, 1'b0, 1'b1, 4'd1, C_DECODE);
        for (int i = 0; i < cycles; i++) begin
            addVec(1'b1, op, fn, 1'b0, 1'b1, 4'd15, C_TRAP);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n     = v.rstN;
        opcode    = v.op;
        funct     = v.fn;
        zero      = v.z;
        mem_ready = v.rdy;
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        #1;
        if (expQ.size() == 0) begin
            checkValue("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            if (IRWrite === 1'b1) irwCount++;
            checkValue("state", 32'(state), 32'(e.st));
            checkValue("ctrl", 32'(actCtrl), 32'(e.ctrl));
            checkValue("retired", 32'(retired), 32'(e.ret));
        end
    endtask

    task automatic runVecs();
        for (int i = 0; i < vecQ.size(); i++) begin
            curVec++;
            applyStimulus(vecQ[i]);
            checkOutput();
        end
        vecQ.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Main table: ADD, funct sweep, ADDI, SW, branches, jump, traps with reset recovery.
        addReset();
        addReset();
        addR(3'b010, 4'b0010);
        addR(3'b000, 4'b0000);
        addR(3'b001, 4'b0001);
        addR(3'b010, 4'b0010);
        addR(3'b011, 4'b0110);
        addR(3'b100, 4'b0111);
        addR(3'b101, 4'b1100);
        addR(3'b110, 4'b1101);
        addVec(1'b1, OP_ADDI, 3'h0, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_ADDI, 3'h0, 1'b0, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, OP_ADDI, 3'h0, 1'b0, 1'b1, 4'd4, C_EXEC_I);
        addVec(1'b1, OP_ADDI, 3'h0, 1'b0, 1'b1, 4'd5, C_I_WB);
        fillRet = fillRet + 16'd1;
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd6, C_EXEC_I);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd9, C_MEM_WR);
        fillRet = fillRet + 16'd1;
        addBranch(OP_BEQ, 1'b1, 1'b1);
        addBranch(OP_BEQ, 1'b0, 1'b0);
        addBranch(OP_BNE, 1'b0, 1'b1);
        addBranch(OP_BNE, 1'b1, 1'b0);
        addJump();
        addTrap(4'b1111, 3'h0, 10);
        addReset();
        addTrap(OP_R, 3'b111, 4);
        addReset();
        runVecs();

        // LW with three stall cycles in FETCH and three in MEM_RD: 11 cycles total.
        irwCount = 0;
        for (int i = 0; i < 3; i++) addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b0, 4'd0, C_FETCH_STALL);
        addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b1, 4'd6, C_EXEC_I);
        for (int i = 0; i < 3; i++) addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b0, 4'd7, C_MEM_RD);
        addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b1, 4'd7, C_MEM_RD);
        addVec(1'b1, OP_LW, 3'h0, 1'b0, 1'b1, 4'd8, C_MEM_WB);
        fillRet = fillRet + 16'd1;
        runVecs();
        checkValue("lw_irwrite_count", 32'(irwCount), 32'd1);
        addVec(1'b1, OP_R, 3'h0, 1'b0, 1'b0, 4'd0, C_FETCH_STALL);
        runVecs();

        // Counter wrap: preload 0xFFFF during a fetch stall, then retire one jump.
        @(negedge clk);
        mem_ready = 1'b0;
        force dut.r_retired = 16'hFFFF;
        #1;
        release dut.r_retired;
        fillRet = 16'hFFFF;
        addVec(1'b1, OP_J, 3'h0, 1'b0, 1'b0, 4'd0, C_FETCH_STALL);
        addJump();
        addVec(1'b1, OP_J, 3'h0, 1'b0, 1'b0, 4'd0, C_FETCH_STALL);
        runVecs();

        // Reset asserted in the middle of a stalled store.
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd1, C_DECODE);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b1, 4'd6, C_EXEC_I);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b0, 4'd9, C_MEM_WR);
        addVec(1'b1, OP_SW, 3'h0, 1'b0, 1'b0, 4'd9, C_MEM_WR);
        runVecs();
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("memwrite_on_reset", 32'(MemWrite), 32'd0);
        checkValue("state_on_reset", 32'(state), 32'd0);
        checkValue("ctrl_on_reset", 32'(actCtrl), 32'(C_ZERO));
        checkValue("retired_on_reset", 32'(retired), 32'd0);
        addReset();
        addVec(1'b1, OP_R, 3'b010, 1'b0, 1'b1, 4'd0, C_FETCH_GO);
        addVec(1'b1, OP_R, 3'b010, 1'b0, 1'b1, 4'd1, C_DECODE);
        runVecs();

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
